// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// counter sizing and the all-ones error quotient.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest quotient the error constant below can cover.
    localparam int MAX_WIDTH = 128;

    localparam logic [MAX_WIDTH-1:0] ERR_QUOT_ONES = '1;

    // Step counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dvd_bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        // Only evaluated into rem_o when shifted >= divisor, so the top bit is never needed.
        diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
        q_bit_o = (shifted >= {2'b00, divisor_i});
        rem_o   = q_bit_o ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_64by32_seq.sv
// Sequential restoring unsigned divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle instead of one.
module div_64by32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in0,
    input  logic [WIDTH-1:0]   in1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic               err_div0,
    output logic               err_ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif

    state_t             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pdiv0_q, pdiv0_d;
    logic               povf_q, povf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out0_q, out0_d;
    logic [WIDTH-1:0]   out1_q, out1_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     rem_chain [STEPS+1];
    logic [STEPS-1:0]   q_bits;
    logic [WIDTH-1:0]   in_hi;

    assign rem_chain[0] = rem_q;
    assign in_hi        = in0[2*WIDTH-1:WIDTH];

    // Steps chain MSB-first: step gi consumes dividend bit WIDTH-1-gi.
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i     (rem_chain[gi]),
            .divisor_i (dsr_q),
            .dvd_bit_i (dvd_q[WIDTH-1-gi]),
            .rem_o     (rem_chain[gi+1]),
            .q_bit_o   (q_bits[STEPS-1-gi])
        );
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        pdiv0_d     = pdiv0_q;
        povf_d      = povf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                    dsr_d      = in1;
                    dvd_d      = in0[WIDTH-1:0];
                    // Error cases park the final result in quo/rem with the counter already
                    // terminal, so they share the normal exit path one edge later.
                    if (in1 == '0) begin
                        pdiv0_d = 1'b1;
                        povf_d  = 1'b0;
                        quo_d   = ERR_QUOT_ONES[WIDTH-1:0];
                        rem_d   = {1'b0, in0[WIDTH-1:0]};
                        cnt_d   = CNT_W'(WIDTH);
                    end else if (in_hi >= in1) begin
                        pdiv0_d = 1'b0;
                        povf_d  = 1'b1;
                        quo_d   = ERR_QUOT_ONES[WIDTH-1:0];
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        pdiv0_d = 1'b0;
                        povf_d  = 1'b0;
                        quo_d   = '0;
                        rem_d   = {1'b0, in_hi};
                        cnt_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    out0_d      = quo_q;
                    out1_d      = rem_q[WIDTH-1:0];
                    div0_d      = pdiv0_q;
                    ovf_d       = povf_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    rem_d = rem_chain[STEPS];
                    dvd_d = dvd_q << STEPS;
                    quo_d = {quo_q[WIDTH-STEPS-1:0], q_bits};
                    cnt_d = cnt_q + CNT_W'(STEPS);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    div0_d      = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            pdiv0_q     <= 1'b0;
            povf_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            pdiv0_q     <= pdiv0_d;
            povf_q      <= povf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign err_div0  = div0_q;
    assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_div_64by32_seq.sv
// Scoreboard bench for div_64by32_seq: expected results are queued at issue
// and compared when the divider presents its result.
module tb_div_64by32_seq;

    localparam int W = 32;
`ifdef DIV_RADIX4_EN
    localparam int LAT = W/2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d0;
        logic         ov;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] in0 = '0;
    logic [W-1:0]   in1 = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out0;
    logic [W-1:0]   out1;
    logic           err_div0;
    logic           err_ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_64by32_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .err_div0  (err_div0),
        .err_ovf   (err_ovf)
    );

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] q64;
        e.d0 = 1'b0;
        e.ov = 1'b0;
        if (b == '0) begin
            e.d0 = 1'b1;
            e.q  = '1;
            e.r  = a[W-1:0];
        end else if (a[2*W-1:W] >= b) begin
            e.ov = 1'b1;
            e.q  = '1;
            e.r  = '0;
        end else begin
            q64 = a / {32'd0, b};
            e.q = q64[W-1:0];
            e.r = W'(a % {32'd0, b});
        end
        return e;
    endfunction

    // Present operands until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in0 = a; in1 = b; in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("issue in0=%h in1=%h", a, b);
    endtask

    task automatic receive(input string name, input int exp_lat,
                           output logic [W-1:0] q_o, output logic [W-1:0] r_o);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        q_o = out0; r_o = out1;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%0b required=1", name, out_valid);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency got=%0d required=%0d", name, lat, exp_lat);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty got=0 required=1 entries", name);
        end else begin
            e = sb.pop_front();
            if ({out0, out1, err_div0, err_ovf} !== {e.q, e.r, e.d0, e.ov}) begin
                errors++;
                $display("FAIL %s q=%h r=%h d0=%0b ov=%0b required q=%h r=%h d0=%0b ov=%0b",
                         name, out0, out1, err_div0, err_ovf, e.q, e.r, e.d0, e.ov);
            end
        end
        $display("result %s q=%h r=%h d0=%0b ov=%0b lat=%0d", name, out0, out1, err_div0, err_ovf, lat);
        if (out_ready) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_div0 !== 1'b0 || err_ovf !== 1'b0) begin
                errors++;
                $display("FAIL %s_handoff v=%0b rdy=%0b d0=%0b ov=%0b required v=0 rdy=1 d0=0 ov=0",
                         name, out_valid, in_ready, err_div0, err_ovf);
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({in_ready, out_valid, out0, out1, err_div0, err_ovf} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 2'b00}) begin
            errors++;
            $display("FAIL %s rdy=%0b v=%0b q=%h r=%h d0=%0b ov=%0b required rdy=1 v=0 q=0 r=0 d0=0 ov=0",
                     name, in_ready, out_valid, out0, out1, err_div0, err_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle_zero("reset");
        $display("reset done");
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r;
        send(64'd100, 32'd7);
        receive("basic_100_7", LAT, q, r);
        send(64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
        receive("roundtrip", LAT, q, r);
        send(64'h00000000_FFFFFFFF, 32'd1);
        receive("div_by_one", LAT, q, r);
        send(64'h00000006_FFFFFFFF, 32'd7);
        receive("max_quot", LAT, q, r);
    endtask

    task automatic test_errors();
        logic [W-1:0] q, r;
        send(64'h12345678_9ABCDEF0, 32'd0);
        receive("div0", 1, q, r);
        send(64'h00000007_00000000, 32'd7);
        receive("ovf_equal", 1, q, r);
        send(64'hFFFFFFFF_FFFFFFFF, 32'h80000000);
        receive("ovf_greater", 1, q, r);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q, r;
        logic [W-1:0] q_hold, r_hold;
        out_ready = 1'b0;
        send(64'h0000ABCD_12345678, 32'h0001F00D);
        // Stray operands during CALC must be ignored.
        for (int i = 0; i < 5; i++) begin
            in0 = {$urandom, $urandom}; in1 = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL calc_in_ready got=%0b required=0", in_ready);
            end
            @(posedge clk); #1;
        end
        receive("backpressure", LAT - 10, q, r);
        q_hold = q; r_hold = r;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out0 !== q_hold || out1 !== r_hold) begin
                errors++;
                $display("FAIL hold_cycle_%0d v=%0b rdy=%0b q=%h r=%h required v=1 rdy=0 q=%h r=%h",
                         i, out_valid, in_ready, out0, out1, q_hold, r_hold);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
        end
        $display("backpressure released");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        send(64'h00001234_55667788, 32'h00ABCDEF);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        check_idle_zero("reset_mid");
        $display("reset mid-calc");
        send(64'd1000, 32'd3);
        receive("after_reset_1000_3", LAT, q, r);
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] a;
        logic [W-1:0]   b, q, r;
        logic [2*W-1:0] recon;
        for (int i = 0; i < 60; i++) begin
            b = $urandom;
            if (b == '0) b = 32'd1;
            a = {W'($urandom % b), W'($urandom)};
            send(a, b);
            receive("random", LAT, q, r);
            recon = {32'd0, q} * {32'd0, b} + {32'd0, r};
            checks++;
            if (recon !== a || r >= b) begin
                errors++;
                $display("FAIL invariant q*b+r=%h required=%h r=%h b=%h", recon, a, r, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
